// File: rtl/qspi_target_model.sv
// qspi_target_model: flash-like QSPI target (SPI mode 0, MSB-first) for
// controller loopback. Oversamples sclk/cs_n/io on clk, decodes
// command/address/dummy phases, and serves reads from or programs writes
// into an internal byte array.
// Optional build macro: QSPI_TGT_WREN_EN adds a write-enable latch
// (0x06 sets, 0x04 clears). Without it, programs always write and
// 0x06/0x04 are unsupported opcodes.
module qspi_target_model #(
  parameter int unsigned IO_WIDTH     = 4,
  parameter int unsigned MEM_BYTES    = 256,
  parameter int unsigned ADDR_BITS    = 24,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out,
  output logic [IO_WIDTH-1:0] io_oe,
  output logic                busy,
  output logic                cmd_err,
  output logic [7:0]          last_cmd
);

  localparam int unsigned MEM_AW = $clog2(MEM_BYTES);
  localparam int unsigned CNT_W  = $clog2(ADDR_BITS + DUMMY_CYCLES + 9);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD_DATA,
    WR_DATA,
    IGNORE
  } state_e;

  typedef enum logic [1:0] {
    LANE1,
    LANE2,
    LANE4
  } lane_e;

  // Input synchronizers
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [IO_WIDTH-1:0]    io_sync_q [SYNC_STAGES];
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic                   sclk_s;
  logic                   cs_s;
  logic [IO_WIDTH-1:0]    io_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_fall;

  // FSM and datapath state
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]             cmd_q, cmd_d;
  logic [MEM_AW-1:0]      addr_q, addr_d;
  lane_e                  lane_q, lane_d;
  logic                   rd_q, rd_d;
  logic                   dummy_q, dummy_d;
  logic [6:0]             rx_q, rx_d;
  logic [7:0]             tx_q, tx_d;
  logic [IO_WIDTH-1:0]    out_q, out_d;
  logic [IO_WIDTH-1:0]    oe_q, oe_d;
  logic                   cmd_err_q, cmd_err_d;
  logic [7:0]             last_cmd_q, last_cmd_d;
`ifdef QSPI_TGT_WREN_EN
  logic                   wel_q, wel_d;
  logic                   prog_q, prog_d;
  logic                   wr_ok_q, wr_ok_d;
`endif

  // Combinational helpers
  logic [7:0]             opcode;
  logic [MEM_AW-1:0]      addr_shift;
  logic [7:0]             rx_next;
  logic [IO_WIDTH-1:0]    out_chunk;
  logic [IO_WIDTH-1:0]    oe_chunk;
  logic [CNT_W-1:0]       step;
  logic                   mem_we;

  logic [7:0]             mem [MEM_BYTES];

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign io_s      = io_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign io_out   = out_q;
  assign io_oe    = oe_q;
  assign busy     = (state_q != IDLE);
  assign cmd_err  = cmd_err_q;
  assign last_cmd = last_cmd_q;

  // Synchronizer chains; left out of reset so a mid-transaction reset
  // cannot fabricate a cs_n falling edge while the pin is still low.
  always_ff @(posedge clk) begin
    sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    io_sync_q[0] <= io_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      io_sync_q[i] <= io_sync_q[i-1];
    end
    sclk_prev_q <= sclk_s;
    cs_prev_q   <= cs_s;
  end

  // Lane-width dependent shift helpers
  always_comb begin
    opcode     = {cmd_q, io_s[0]};
    addr_shift = {addr_q[MEM_AW-2:0], io_s[0]};
    case (lane_q)
      LANE4: begin
        rx_next   = {rx_q[3:0], io_s[3:0]};
        out_chunk = tx_q[7:4];
        oe_chunk  = 4'b1111;
        step      = CNT_W'(4);
      end
      LANE2: begin
        rx_next   = {rx_q[5:0], io_s[1:0]};
        out_chunk = {2'b00, tx_q[7:6]};
        oe_chunk  = 4'b0011;
        step      = CNT_W'(2);
      end
      default: begin
        rx_next   = {rx_q[6:0], io_s[0]};
        out_chunk = {2'b00, tx_q[7], 1'b0};
        oe_chunk  = 4'b0010;
        step      = CNT_W'(1);
      end
    endcase
  end

  // Next-state and datapath decode
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    lane_d     = lane_q;
    rd_d       = rd_q;
    dummy_d    = dummy_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    out_d      = out_q;
    oe_d       = oe_q;
    cmd_err_d  = 1'b0;
    last_cmd_d = last_cmd_q;
    mem_we     = 1'b0;
`ifdef QSPI_TGT_WREN_EN
    wel_d      = wel_q;
    prog_d     = prog_q;
    wr_ok_d    = wr_ok_q;
`endif

    if (state_q != IDLE && cs_s) begin
      // cs_n high ends any transaction; partial bytes are dropped.
      state_d = IDLE;
      out_d   = '0;
      oe_d    = '0;
`ifdef QSPI_TGT_WREN_EN
      if (prog_q) begin
        wel_d = 1'b0;
      end
      prog_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d   = CMD;
            bit_cnt_d = '0;
          end
        end

        CMD: begin
          if (sclk_rise) begin
            cmd_d     = opcode[6:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d  = '0;
              last_cmd_d = opcode;
              state_d    = ADDR;
              rd_d       = 1'b0;
              dummy_d    = 1'b0;
              lane_d     = LANE1;
              case (opcode)
                8'h03: rd_d = 1'b1;
                8'h3B: begin
                  rd_d    = 1'b1;
                  dummy_d = 1'b1;
                  lane_d  = LANE2;
                end
                8'h6B: begin
                  rd_d    = 1'b1;
                  dummy_d = 1'b1;
                  lane_d  = LANE4;
                end
                8'h02: begin
`ifdef QSPI_TGT_WREN_EN
                  prog_d  = 1'b1;
                  wr_ok_d = wel_q;
`endif
                end
                8'h32: begin
                  lane_d = LANE4;
`ifdef QSPI_TGT_WREN_EN
                  prog_d  = 1'b1;
                  wr_ok_d = wel_q;
`endif
                end
`ifdef QSPI_TGT_WREN_EN
                8'h06: begin
                  wel_d   = 1'b1;
                  state_d = IGNORE;
                end
                8'h04: begin
                  wel_d   = 1'b0;
                  state_d = IGNORE;
                end
`endif
                default: begin
                  cmd_err_d = 1'b1;
                  state_d   = IGNORE;
                end
              endcase
            end
          end
        end

        ADDR: begin
          if (sclk_rise) begin
            addr_d    = addr_shift;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(ADDR_BITS - 1)) begin
              bit_cnt_d = '0;
              rx_d      = '0;
              if (!rd_q) begin
                state_d = WR_DATA;
              end else if (dummy_q && (DUMMY_CYCLES != 0)) begin
                state_d = DUMMY;
              end else begin
                tx_d    = mem[addr_shift];
                state_d = RD_DATA;
              end
            end
          end
        end

        DUMMY: begin
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
              bit_cnt_d = '0;
              tx_d      = mem[addr_q];
              state_d   = RD_DATA;
            end
          end
        end

        RD_DATA: begin
          // The last chunk of a byte reloads the shifter with the next
          // address so the following falling edge continues without a gap.
          if (sclk_fall) begin
            out_d = out_chunk;
            oe_d  = oe_chunk;
            if (bit_cnt_q == CNT_W'(8) - step) begin
              bit_cnt_d = '0;
              addr_d    = addr_q + MEM_AW'(1);
              tx_d      = mem[addr_q + MEM_AW'(1)];
            end else begin
              bit_cnt_d = bit_cnt_q + step;
              tx_d      = tx_q << step;
            end
          end
        end

        WR_DATA: begin
          if (sclk_rise) begin
            rx_d      = rx_next[6:0];
            bit_cnt_d = bit_cnt_q + step;
            if (bit_cnt_q == CNT_W'(8) - step) begin
`ifdef QSPI_TGT_WREN_EN
              mem_we = wr_ok_q;
`else
              mem_we = 1'b1;
`endif
              bit_cnt_d = '0;
              addr_d    = addr_q + MEM_AW'(1);
            end
          end
        end

        IGNORE: ;

        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      lane_q     <= LANE1;
      rd_q       <= 1'b0;
      dummy_q    <= 1'b0;
      rx_q       <= '0;
      tx_q       <= '0;
      out_q      <= '0;
      oe_q       <= '0;
      cmd_err_q  <= 1'b0;
      last_cmd_q <= '0;
`ifdef QSPI_TGT_WREN_EN
      wel_q      <= 1'b0;
      prog_q     <= 1'b0;
      wr_ok_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      lane_q     <= lane_d;
      rd_q       <= rd_d;
      dummy_q    <= dummy_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      cmd_err_q  <= cmd_err_d;
      last_cmd_q <= last_cmd_d;
`ifdef QSPI_TGT_WREN_EN
      wel_q      <= wel_d;
      prog_q     <= prog_d;
      wr_ok_q    <= wr_ok_d;
`endif
    end
  end

  // Byte array; contents survive reset, a reset cycle blocks the commit
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) begin
      mem[addr_q] <= rx_next;
    end
  end

endmodule

// File: tb/tb_qspi_target_model.sv
// tb_qspi_target_model: directed, table-driven bench for qspi_target_model
// (default build, write-enable latch macro undefined).
module tb_qspi_target_model;

  localparam int HALF = 50;  // sclk half period: 5 clk periods

  typedef enum {K_RD, K_WR, K_BAD} kind_e;

  typedef struct {
    kind_e       kind;
    logic [7:0]  op;
    logic [23:0] addr;
    int unsigned lanes;
    int unsigned dummy;
    int unsigned nbytes;
    logic [31:0] data;    // first byte in [31:24]
    logic [3:0]  exp_oe;  // expected io_oe during read data
    int unsigned exp_err; // expected cmd_err pulses
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       sclk;
  logic       cs_n;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic       busy;
  logic       cmd_err;
  logic [7:0] last_cmd;

  int unsigned checks;
  int unsigned failures;
  int unsigned err_pulses;
  logic        ctl_oe_bad;

  vec_t vecs [12];

  qspi_target_model #(
    .IO_WIDTH    (4),
    .MEM_BYTES   (256),
    .ADDR_BITS   (24),
    .DUMMY_CYCLES(8),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .io_in   (io_in),
    .io_out  (io_out),
    .io_oe   (io_oe),
    .busy    (busy),
    .cmd_err (cmd_err),
    .last_cmd(last_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_err) err_pulses++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One sclk period: drive during the low phase, sample just before the rise
  task automatic cyc(input logic [3:0] d, output logic [3:0] o, output logic [3:0] oe);
    io_in = d;
    #(HALF);
    o  = io_out;
    oe = io_oe;
    sclk = 1'b1;
    #(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_single(input logic [31:0] val, input int nbits);
    logic [3:0] o;
    logic [3:0] oe;
    for (int i = nbits - 1; i >= 0; i--) begin
      cyc({3'b000, val[i]}, o, oe);
      if (oe != 4'h0) ctl_oe_bad = 1'b1;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [3:0]  o;
    logic [3:0]  oe;
    logic [3:0]  d;
    logic [31:0] tmp;
    logic [31:0] rd;
    logic        data_oe_bad;
    int unsigned errs0;
    errs0       = err_pulses;
    ctl_oe_bad  = 1'b0;
    data_oe_bad = 1'b0;
    rd          = '0;
    cs_n = 1'b0;
    #(HALF);
    send_single({24'h0, v.op}, 8);
    if (v.kind == K_BAD) begin
      for (int i = 0; i < 32; i++) begin
        cyc(4'($urandom_range(0, 15)), o, oe);
        if (oe != 4'h0) ctl_oe_bad = 1'b1;
      end
    end else begin
      send_single({8'h0, v.addr}, 24);
      for (int i = 0; i < int'(v.dummy); i++) begin
        cyc(4'h0, o, oe);
        if (oe != 4'h0) ctl_oe_bad = 1'b1;
      end
      for (int i = 0; i < int'(v.nbytes * 8 / v.lanes); i++) begin
        tmp = v.data << (i * int'(v.lanes));
        if (v.kind == K_RD) d = 4'h0;
        else if (v.lanes == 4) d = tmp[31:28];
        else if (v.lanes == 2) d = {2'b00, tmp[31:30]};
        else d = {3'b000, tmp[31]};
        cyc(d, o, oe);
        if (v.kind == K_RD) begin
          if (v.lanes == 4) rd = {rd[27:0], o};
          else if (v.lanes == 2) rd = {rd[29:0], o[1:0]};
          else rd = {rd[30:0], o[1]};
          if (oe != v.exp_oe) data_oe_bad = 1'b1;
        end else if (oe != 4'h0) begin
          ctl_oe_bad = 1'b1;
        end
      end
    end
    #(HALF);
    cs_n = 1'b1;
    #(4 * HALF);
    check({tag, " last_cmd"}, 32'(last_cmd), 32'(v.op));
    check({tag, " cmd_err_pulses"}, err_pulses - errs0, v.exp_err);
    check({tag, " oe_outside_data"}, 32'(ctl_oe_bad), 32'h0);
    check({tag, " busy_after"}, 32'(busy), 32'h0);
    if (v.kind == K_RD) begin
      check({tag, " read_data"}, rd, v.data >> (32 - 8 * v.nbytes));
      check({tag, " oe_in_data"}, 32'(data_oe_bad), 32'h0);
    end
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [3:0] o;
    logic [3:0] oe;

    checks     = 0;
    failures   = 0;
    err_pulses = 0;
    ctl_oe_bad = 1'b0;
    reset_n    = 1'b0;
    sclk       = 1'b0;
    cs_n       = 1'b1;
    io_in      = 4'h0;

    //          kind   op     addr        ln dm nb data          oe       err
    vecs[0]  = '{K_WR,  8'h02, 24'h000010, 1, 0, 2, 32'hA53C0000, 4'b0000, 0};
    vecs[1]  = '{K_RD,  8'h03, 24'h000010, 1, 0, 2, 32'hA53C0000, 4'b0010, 0};
    vecs[2]  = '{K_RD,  8'h6B, 24'h000010, 4, 8, 2, 32'hA53C0000, 4'b1111, 0};
    vecs[3]  = '{K_RD,  8'h3B, 24'h000010, 2, 8, 2, 32'hA53C0000, 4'b0011, 0};
    vecs[4]  = '{K_WR,  8'h32, 24'h0000FF, 4, 0, 2, 32'h11220000, 4'b0000, 0};
    vecs[5]  = '{K_RD,  8'h03, 24'h0000FF, 1, 0, 2, 32'h11220000, 4'b0010, 0};
    vecs[6]  = '{K_RD,  8'h6B, 24'h000000, 4, 8, 1, 32'h22000000, 4'b1111, 0};
    vecs[7]  = '{K_RD,  8'h03, 24'hABCD10, 1, 0, 1, 32'hA5000000, 4'b0010, 0};
    vecs[8]  = '{K_BAD, 8'h9F, 24'h000000, 1, 0, 0, 32'h00000000, 4'b0000, 1};
    vecs[9]  = '{K_WR,  8'h02, 24'h000020, 1, 0, 2, 32'h00770000, 4'b0000, 0};
    vecs[10] = '{K_BAD, 8'h06, 24'h000000, 1, 0, 0, 32'h00000000, 4'b0000, 1};
    vecs[11] = '{K_RD,  8'h3B, 24'h0000FF, 2, 8, 2, 32'h11220000, 4'b0011, 0};

    // Reset state (stimulus stays 2 ns past each clk falling edge)
    #102;
    check("rst io_out", 32'(io_out), 32'h0);
    check("rst io_oe", 32'(io_oe), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst cmd_err", 32'(cmd_err), 32'h0);
    check("rst last_cmd", 32'(last_cmd), 32'h0);
    reset_n = 1'b1;
    #100;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Abort: second program byte cut after 4 bits
    cs_n = 1'b0;
    #(HALF);
    send_single(32'h02, 8);
    send_single(32'h000020, 24);
    send_single(32'h5A, 8);
    send_single(32'hF, 4);
    check("abort busy_mid", 32'(busy), 32'h1);
    #(HALF);
    cs_n = 1'b1;
    #28;
    check("abort busy_3clk", 32'(busy), 32'h0);
    #172;
    v = '{K_RD, 8'h03, 24'h000020, 1, 0, 2, 32'h5A770000, 4'b0010, 0};
    run_vec("abort_readback", v);

    // Reset pulse in the middle of a read
    cs_n = 1'b0;
    #(HALF);
    send_single(32'h03, 8);
    send_single(32'h000010, 24);
    for (int i = 0; i < 4; i++) cyc(4'h0, o, oe);
    check("midrst oe_before", 32'(io_oe), 32'h2);
    check("midrst busy_before", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #6;
    check("midrst oe_after", 32'(io_oe), 32'h0);
    check("midrst busy_after", 32'(busy), 32'h0);
    check("midrst io_out_after", 32'(io_out), 32'h0);
    #4;
    reset_n = 1'b1;
    #40;
    cs_n = 1'b1;
    #(4 * HALF);
    v = '{K_RD, 8'h03, 24'h000010, 1, 0, 2, 32'hA53C0000, 4'b0010, 0};
    run_vec("midrst_recover", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
